// File: rtl/prince_inv_sbox_layer_glm.sv
// Masked PRINCE inverse S-box layer, nibble-serial, 2 shares, GLM expansion.
// Ports: clk, rst (sync, active-high), start, in_s0/in_s1 (input shares),
//   rnd (refresh bits), busy, done (pulse), out_s0/out_s1 (result shares).
// Build option: define GLM_REFRESH_EN to XOR rnd into the cross-domain terms.
module prince_inv_sbox_layer_glm (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] in_s0,
  input  logic [63:0] in_s1,
  input  logic [3:0]  rnd,
  output logic        busy,
  output logic        done,
  output logic [63:0] out_s0,
  output logic [63:0] out_s1
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        dcnt;
  logic [63:0] sh0;
  logic [63:0] sh1;

  logic        v1;
  logic [3:0]  idx1;
  logic [3:0]  p00;
  logic [3:0]  p01;
  logic [3:0]  p10;
  logic [3:0]  p11;

  logic        v2;
  logic [3:0]  idx2;
  logic [3:0]  q0;
  logic [3:0]  q1;

  logic [3:0]  na;
  logic [3:0]  nb;
  logic [3:0]  r;
  logic [15:0] ex;

  function automatic logic [3:0] sinv(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hB;
      4'h1: y = 4'h7;
      4'h2: y = 4'h3;
      4'h3: y = 4'h2;
      4'h4: y = 4'hF;
      4'h5: y = 4'hD;
      4'h6: y = 4'h8;
      4'h7: y = 4'h9;
      4'h8: y = 4'hA;
      4'h9: y = 4'h6;
      4'hA: y = 4'h4;
      4'hB: y = 4'h0;
      4'hC: y = 4'h5;
      4'hD: y = 4'hE;
      4'hE: y = 4'hC;
      default: y = 4'h1;
    endcase
    return y;
  endfunction

  // Algebraic normal form of output bit b (Moebius transform of the table).
  // Entry m is the coefficient of the monomial prod_{i in m} x_i.
  function automatic logic [15:0] anf(input int b);
    logic [15:0] t;
    logic [3:0]  s;
    t = '0;
    for (int x = 0; x < 16; x++) begin
      s = sinv(4'(x));
      t[x] = s[b];
    end
    for (int i = 0; i < 4; i++) begin
      for (int x = 0; x < 16; x++) begin
        if (((x >> i) & 1) == 1)
          t[x] = t[x] ^ t[x ^ (1 << i)];
      end
    end
    return t;
  endfunction

  // Share expansion of every cubic monomial over x = a ^ b.
  // Each sub-term takes bits u from share a and m\u from share b:
  // pure-a -> d00, pure-b -> d11, mixed terms go to d01 when share a
  // dominates the term, otherwise to d10.
  function automatic logic [15:0] expand(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0]  d00;
    logic [3:0]  d01;
    logic [3:0]  d10;
    logic [3:0]  d11;
    logic [15:0] c;
    logic [3:0]  m4;
    logic [3:0]  u4;
    logic [3:0]  w4;
    logic        tm;
    d00 = '0;
    d01 = '0;
    d10 = '0;
    d11 = '0;
    for (int o = 0; o < 4; o++) begin
      c = anf(o);
      for (int m = 0; m < 16; m++) begin
        for (int u = 0; u < 16; u++) begin
          m4 = 4'(m);
          u4 = 4'(u);
          w4 = m4 & ~u4;
          if (c[m] && ((u4 & ~m4) == 4'd0)) begin
            tm = ((a & u4) == u4) && ((b & w4) == w4);
            if (u4 == m4)
              d00[o] = d00[o] ^ tm;
            else if (u4 == 4'd0)
              d11[o] = d11[o] ^ tm;
            else if ($countones(u4) >= $countones(w4))
              d01[o] = d01[o] ^ tm;
            else
              d10[o] = d10[o] ^ tm;
          end
        end
      end
    end
    return {d11, d10, d01, d00};
  endfunction

  assign na = sh0[{cnt, 2'b00} +: 4];
  assign nb = sh1[{cnt, 2'b00} +: 4];

`ifdef GLM_REFRESH_EN
  assign r = rnd;
`else
  logic unused_rnd;
  assign unused_rnd = ^rnd;
  assign r = 4'd0;
`endif

  always_comb begin
    ex = expand(na, nb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dcnt   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sh0    <= '0;
      sh1    <= '0;
      v1     <= 1'b0;
      idx1   <= '0;
      p00    <= '0;
      p01    <= '0;
      p10    <= '0;
      p11    <= '0;
      v2     <= 1'b0;
      idx2   <= '0;
      q0     <= '0;
      q1     <= '0;
      out_s0 <= '0;
      out_s1 <= '0;
    end else begin
      done <= 1'b0;
      v1   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sh0   <= in_s0;
            sh1   <= in_s1;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          v1   <= 1'b1;
          idx1 <= cnt;
          p00  <= ex[3:0];
          // same refresh bit into both cross terms; cancels in stage 2
          p01  <= ex[7:4] ^ r;
          p10  <= ex[11:8] ^ r;
          p11  <= ex[15:12];
          cnt  <= cnt + 4'd1;
          dcnt <= 1'b0;
          if (cnt == 4'd15)
            state <= DRAIN;
        end
        DRAIN: begin
          dcnt <= ~dcnt;
          if (dcnt) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      v2   <= v1;
      idx2 <= idx1;
      q0   <= p00 ^ p01;
      q1   <= p11 ^ p10;
      if (v2) begin
        out_s0[{idx2, 2'b00} +: 4] <= q0;
        out_s1[{idx2, 2'b00} +: 4] <= q1;
      end
    end
  end

endmodule

// File: tb/tb_prince_inv_sbox_layer_glm.sv
// Directed bench for prince_inv_sbox_layer_glm.
// Checks results, latency, start handling and reset abort.
module tb_prince_inv_sbox_layer_glm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] in_s0;
  logic [63:0] in_s1;
  logic [3:0]  rnd;
  logic        busy;
  logic        done;
  logic [63:0] out_s0;
  logic [63:0] out_s1;

  int n_tests;
  int n_fail;

  localparam logic [63:0] K_IN  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K_OUT = 64'hB732FD89A6405EC1;

  prince_inv_sbox_layer_glm dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in_s0  (in_s0),
    .in_s1  (in_s1),
    .rnd    (rnd),
    .busy   (busy),
    .done   (done),
    .out_s0 (out_s0),
    .out_s1 (out_s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One operation; lat counts edges from acceptance (1) to done.
  task automatic run_op(
    input  logic [63:0] s0,
    input  logic [63:0] s1,
    input  logic        mid,
    output logic [63:0] res,
    output int          lat,
    output logic        bz,
    output logic        pok
  );
    @(negedge clk);
    in_s0 = s0;
    in_s1 = s1;
    rnd   = 4'($urandom);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      rnd = 4'($urandom);
      if (mid && lat == 5)
        start = 1'b1;
      if (lat == 9)
        start = 1'b0;
    end
    start = 1'b0;
    res = out_s0 ^ out_s1;
    bz  = busy;
    @(posedge clk);
    #1;
    pok = !done && !busy;
  endtask

  logic [63:0] res;
  logic [63:0] m;
  int          lat;
  logic        bz;
  logic        pok;
  int          d1;
  int          d2;
  int          nd;
  int          bl;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    start = 1'b0;
    in_s0 = '0;
    in_s1 = '0;
    rnd   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out0", out_s0, 64'd0);
    check("rst_out1", out_s1, 64'd0);

    run_op(64'd0, 64'd0, 1'b0, res, lat, bz, pok);
    check("zero_res", res, 64'hBBBBBBBBBBBBBBBB);
    check("zero_lat", 64'(lat), 64'd19);
    check("zero_busy", 64'(bz), 64'd1);
    check("zero_pulse", 64'(pok), 64'd1);

    run_op(K_IN, 64'd0, 1'b0, res, lat, bz, pok);
    check("k_res", res, K_OUT);
    check("k_lat", 64'(lat), 64'd19);

    run_op(64'hF0F0F0F00F0F0F0F, 64'h0F0F0F0FF0F0F0F0,
           1'b0, res, lat, bz, pok);
    check("ones_res", res, 64'h1111111111111111);

    run_op(64'h123456789ABCDEF0, 64'hECE8ECE0ECE8ECE0,
           1'b1, res, lat, bz, pok);
    check("mid_res", res, 64'h1CE5046A98DF237B);
    check("mid_lat", 64'(lat), 64'd19);
    check("mid_pulse", 64'(pok), 64'd1);

    repeat (5) @(posedge clk);
    #1;
    check("hold_res", out_s0 ^ out_s1, 64'h1CE5046A98DF237B);

    for (int i = 0; i < 100; i++) begin
      m = {$urandom, $urandom};
      run_op(m, m ^ K_IN, 1'b0, res, lat, bz, pok);
      check($sformatf("mask%0d", i), res, K_OUT);
      if (lat != 19)
        check($sformatf("mask_lat%0d", i), 64'(lat), 64'd19);
    end

    @(negedge clk);
    in_s0 = 64'hFFFFFFFFFFFFFFFF;
    in_s1 = 64'hFFFFFFFFFFFFFFFF;
    start = 1'b1;
    d1 = -1;
    d2 = -1;
    nd = 0;
    bl = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      rnd = 4'($urandom);
      if (k == 39)
        start = 1'b0;
      if (done) begin
        nd++;
        if (d1 < 0)
          d1 = k;
        else
          d2 = k;
      end
      if (d1 >= 0 && d2 < 0 && !busy)
        bl++;
    end
    check("held_ndone", 64'(nd), 64'd2);
    check("held_gap", 64'(d2 - d1), 64'd20);
    check("held_busylow", 64'(bl), 64'd1);
    check("held_res", out_s0 ^ out_s1, 64'hBBBBBBBBBBBBBBBB);

    @(negedge clk);
    in_s0 = 64'h5555AAAA5555AAAA;
    in_s1 = 64'h5555AAAA5555AAAA ^ K_IN;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out0", out_s0, 64'd0);
    check("abort_out1", out_s1, 64'd0);
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done)
        nd++;
    end
    check("abort_nodone", 64'(nd), 64'd0);

    run_op(64'h5555AAAA5555AAAA, 64'h5555AAAA5555AAAA ^ K_IN,
           1'b0, res, lat, bz, pok);
    check("after_rst_res", res, K_OUT);
    check("after_rst_lat", 64'(lat), 64'd19);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prince_inv_sbox_layer_glm.md
PRINCE_INV_SBOX_LAYER_GLM -- requirements
Module: prince_inv_sbox_layer_glm

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request to process one 64-bit state; sampled only in IDLE.
REQ-004 The block SHALL have the ports in_s0 and in_s1, inputs, 64 bits each: Boolean shares of the input state (value = in_s0 ^ in_s1); captured on the cycle start is accepted.
REQ-005 The block SHALL have the port rnd, input, 4 bits: fresh randomness, used for one nibble per cycle while RUN.
REQ-006 The block SHALL have the port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-007 The block SHALL have the port done, output, 1 bit: one-cycle pulse when out_s0 and out_s1 are complete.
REQ-008 The block SHALL have the ports out_s0 and out_s1, outputs, 64 bits each: shares of the result; held stable from done until the next accepted start.

Function
REQ-009 Unmasked result nibble i SHALL be Sinv(nibble i of in_s0 ^ in_s1), Sinv = {B,7,3,2,F,D,8,9,A,6,4,0,5,E,C,1} for inputs 0..F.
REQ-010 The block SHALL process nibbles serially, LSB nibble first (bits [3:0] = nibble 0), through a 4-bit nibble counter running 0..15.
REQ-011 Each nibble SHALL pass through a 2-stage masked pipeline: stage 1 computes the 4 domain products (s0s0, s0s1, s1s0, s1s1) of the degree-3 share expansion, registered; stage 2 compresses them into 2 output shares, registered.
REQ-012 No stage-1 register SHALL combine values from both shares unmasked; cross-domain terms SHALL be registered before being XORed with any same-domain term.
REQ-013 The FSM SHALL have the states IDLE -> RUN (16 cycles, one nibble issued per cycle) -> DRAIN (2 cycles) -> DONE (1 cycle) -> IDLE.
REQ-014 done SHALL assert exactly 19 cycles after the cycle in which start is accepted in IDLE.
REQ-015 start SHALL be ignored while busy is high or done is high; no queuing.
REQ-016 start high and done high in the same cycle SHALL NOT be accepted; acceptance SHALL occur in the following IDLE cycle if start is still high.
REQ-017 The counter SHALL wrap from 15 to 0 when leaving RUN; nibble 15 SHALL NOT be reissued.
REQ-018 Result nibble i SHALL be written into out_s0 and out_s1 2 cycles after issue; other nibbles SHALL remain unchanged.

Reset
REQ-019 While rst is high on a clock edge, the FSM SHALL go to IDLE, the counter to 0, busy and done to 0, out_s0 and out_s1 to 0, and all pipeline registers to 0.
REQ-020 Reset asserted mid-operation SHALL abort the operation; no done SHALL be produced for the aborted state.

Configuration
REQ-021 With GLM_REFRESH_EN defined, rnd[3:0] SHALL be XORed into the cross-domain stage-1 terms (same bit into s0s1 and s1s0 pairs) so the stage-2 sum cancels it.
REQ-022 With GLM_REFRESH_EN undefined, rnd SHALL be ignored, and the functional results and latency SHALL be identical to those with the macro defined.

Verification
REQ-023 in_s0=0, in_s1=0, start pulse: done at cycle +19, and out_s0^out_s1 = 0xBBBBBBBBBBBBBBBB.
REQ-024 A random mask M with in_s0=M and in_s1=M^0x0123456789ABCDEF, with random rnd: out_s0^out_s1 = 0xB732FD89A6405EC1; the test SHALL repeat with 100 different masks.
REQ-025 start held high for 40 cycles: exactly two operations run, with done pulses 20 cycles apart and busy low for 1 cycle between them.
REQ-026 rst raised at cycle +8 of an operation: the next cycle has busy=0, out_s0=out_s1=0, and no done pulse; a new start then completes normally.
REQ-027 Both macro settings with identical stimulus: outputs SHALL be bit-identical per share when rnd=0, and the unmasked value SHALL be equal for any rnd.
